// File: rtl/weight_buf_pkg.sv
// Shared constants, sequencer state encoding and a width helper for the
// ping-pong weight buffer.
package weight_buf_pkg;

    localparam int DW          = 16;
    localparam int KS_MAX      = 5;
    localparam int SLICE_WORDS = KS_MAX * KS_MAX;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/weight_bank.sv
// One weight bank: full-slice write port, combinational single-word read.
// Contents are intentionally not reset.
module weight_bank #(
    parameter int DW       = 16,
    parameter int KS_MAX   = 5,
    parameter int SLICES   = 4,
    parameter int SLICE_AW = 2,
    parameter int AW       = 7
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [SLICE_AW-1:0]         wr_slice,
    input  logic [KS_MAX*KS_MAX*DW-1:0] wr_data,
    input  logic [AW-1:0]               rd_addr,
    output logic [DW-1:0]               rd_data
);
    import weight_buf_pkg::*;

    localparam int SW = KS_MAX * KS_MAX;

    logic [DW-1:0] mem_q [SLICES*SW];
    logic [AW-1:0] wr_base;

    assign wr_base = AW'(wr_slice) * AW'(SW);

    // store a whole slice in one cycle; out-of-range slice indices are dropped
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_slice) < SLICES)) begin
            for (int i = 0; i < SW; i++) begin
                mem_q[wr_base + AW'(i)] <= wr_data[DW*i +: DW];
            end
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/weight_pingpong_buffer.sv
// Double-buffered convolution weight store with a valid/ready read sequencer.
//   state    | meaning
//   S_IDLE   | waiting for rd_start; swaps apply immediately
//   S_STREAM | presenting words of one slice, one per accepted transfer
//   S_DONE   | one-cycle done pulse; deferred swap applies on exit
module weight_pingpong_buffer #(
    parameter int DW       = weight_buf_pkg::DW,
    parameter int KS_MAX   = weight_buf_pkg::KS_MAX,
    parameter int SLICES   = 4,
    parameter int SLICE_AW = 2,
    parameter int KSW      = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [SLICE_AW-1:0]         wr_slice,
    input  logic [KS_MAX*KS_MAX*DW-1:0] wr_data,
    input  logic                        swap,
    input  logic                        rd_start,
    input  logic [SLICE_AW-1:0]         rd_slice,
    input  logic [KSW-1:0]              rd_ks,
    output logic [DW-1:0]               out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        rd_err,
    output logic                        bank_sel
);
    import weight_buf_pkg::*;

    localparam int SW = KS_MAX * KS_MAX;
    localparam int AW = clog2(SLICES * SW);
    localparam int LW = 2 * KSW;

    state_t        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [LW-1:0] len_q, len_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          rd_err_q, rd_err_d;
    logic          bank_sel_q, bank_sel_d;
    logic          swap_pend_q, swap_pend_d;

    logic [AW-1:0] rd_addr;
    logic          rd_bank;
    logic [DW-1:0] rd_word0, rd_word1, rd_word;
    logic          req_ok;

    // bank 0 is the fill bank while bank 1 is active, and vice versa
    weight_bank #(.DW(DW), .KS_MAX(KS_MAX), .SLICES(SLICES), .SLICE_AW(SLICE_AW), .AW(AW)) u_bank0 (
        .clk      (clk),
        .wr_en    (wr_en & bank_sel_q),
        .wr_slice (wr_slice),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_word0)
    );

    weight_bank #(.DW(DW), .KS_MAX(KS_MAX), .SLICES(SLICES), .SLICE_AW(SLICE_AW), .AW(AW)) u_bank1 (
        .clk      (clk),
        .wr_en    (wr_en & ~bank_sel_q),
        .wr_slice (wr_slice),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_word1)
    );

    assign req_ok = (rd_ks != '0) && (32'(rd_ks) <= KS_MAX) && (32'(rd_slice) < SLICES);

    // read port: slice base (in the post-swap active bank) when accepting, else the next word
    always_comb begin
        rd_addr = base_q + idx_q + AW'(1);
        rd_bank = bank_sel_q;
        if (state_q == S_IDLE) begin
            rd_addr = AW'(rd_slice) * AW'(SW);
            rd_bank = bank_sel_q ^ swap;
        end
    end

    assign rd_word = rd_bank ? rd_word1 : rd_word0;

    // sequencer next-state, bank select and output register updates
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        idx_d       = idx_q;
        len_d       = len_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        rd_err_d    = 1'b0;
        bank_sel_d  = bank_sel_q;
        swap_pend_d = swap_pend_q;
        case (state_q)
            S_IDLE: begin
                if (swap) bank_sel_d = ~bank_sel_q;
                if (rd_start) begin
                    if (req_ok) begin
                        base_d      = rd_addr;
                        len_d       = LW'(rd_ks) * LW'(rd_ks);
                        idx_d       = '0;
                        out_data_d  = rd_word;
                        out_valid_d = 1'b1;
                        state_d     = S_STREAM;
                    end else begin
                        rd_err_d = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (swap) swap_pend_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    if ((idx_q + AW'(1)) == AW'(len_q)) begin
                        out_valid_d = 1'b0;
                        state_d     = S_DONE;
                    end else begin
                        idx_d      = idx_q + AW'(1);
                        out_data_d = rd_word;
                    end
                end
            end
            S_DONE: begin
                if (swap_pend_q || swap) bank_sel_d = ~bank_sel_q;
                swap_pend_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            rd_err_q    <= 1'b0;
            bank_sel_q  <= 1'b0;
            swap_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            rd_err_q    <= rd_err_d;
            bank_sel_q  <= bank_sel_d;
            swap_pend_q <= swap_pend_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign rd_err    = rd_err_q;
    assign bank_sel  = bank_sel_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule
